// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin arbiter sharing one registered WIDTH-bit adder among NUM_REQ requesters.
// Define ADDER_SCHED_OVF_EN to add the registered signed-overflow output res_ovf.
module adder_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_flat,
    input  logic [NUM_REQ*WIDTH-1:0] b_flat,
    input  logic [NUM_REQ-1:0]       c_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [IDW-1:0]           res_id,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_cout
`ifdef ADDER_SCHED_OVF_EN
    ,
    output logic                     res_ovf
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;
    logic [IDW-1:0] ptr, win;
    logic found, accept;
    int idx;
    logic [WIDTH-1:0] op_a, op_b;
    logic op_c;
    logic [WIDTH:0] sum;
    // First set request at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                accept     = found;
                state_next = found ? CALC : IDLE;
            end
            CALC:    state_next = DONE;
            DONE:    state_next = res_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end
    // Gated by rst_n so grant reads 0 while reset is held.
    assign grant     = (accept && rst_n) ? (NUM_REQ'(1) << win) : '0;
    assign busy      = state != IDLE;
    assign res_valid = state == DONE;
    assign sum       = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_c};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_c     <= 1'b0;
            res_id   <= '0;
            res_sum  <= '0;
            res_cout <= 1'b0;
`ifdef ADDER_SCHED_OVF_EN
            res_ovf  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                op_a   <= a_flat[int'(win)*WIDTH +: WIDTH];
                op_b   <= b_flat[int'(win)*WIDTH +: WIDTH];
                op_c   <= c_in[win];
                res_id <= win;
                ptr    <= (win == IDW'(NUM_REQ-1)) ? '0 : win + 1'b1;
            end
            if (state == CALC) begin
                {res_cout, res_sum} <= sum;
`ifdef ADDER_SCHED_OVF_EN
                res_ovf <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: vector table, hand sequences and randomized ops against a behavioural model.
module tb_adder_rr_scheduler;
    localparam int N = 4;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] a_flat, b_flat;
    logic [N-1:0] cin = '0;
    logic [N-1:0] grant;
    logic busy, res_valid, res_cout;
    logic res_ready = 1'b0;
    logic [1:0] res_id;
    logic [W-1:0] res_sum;
    logic [W-1:0] a_l [N];
    logic [W-1:0] b_l [N];
`ifdef ADDER_SCHED_OVF_EN
    logic res_ovf;
`endif
    int passed = 0, total = 0, mdl_ptr = 0, cyc = 0;

    adder_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
        .c_in(cin), .grant(grant), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout)
`ifdef ADDER_SCHED_OVF_EN
        , .res_ovf(res_ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int i = 0; i < N; i++) begin
            a_flat[i*W +: W] = a_l[i];
            b_flat[i*W +: W] = b_l[i];
        end
    end

    typedef struct {
        logic [3:0]  r;
        logic [31:0] a, b;
        logic        c;
        int          stall;
        logic [1:0]  id;
        logic [31:0] sum;
        logic        cout, ovf;
    } vec_t;
    vec_t vt [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic randomize_lanes();
        for (int i = 0; i < N; i++) begin
            a_l[i] = $urandom;
            b_l[i] = $urandom;
            cin[i] = 1'($urandom);
        end
    endtask

    // Starts at a negedge in IDLE and ends at a negedge back in IDLE.
    task automatic run_op(input logic [3:0] r, input int stall,
                          output logic [1:0] o_id, output logic [31:0] o_sum,
                          output logic o_cout, output logic o_ovf);
        int w;
        logic [32:0] s;
        logic e_ovf;
        w = pick(r, mdl_ptr);
        s = {1'b0, a_l[w]} + {1'b0, b_l[w]} + 33'(cin[w]);
        e_ovf = (a_l[w][31] == b_l[w][31]) && (s[31] != a_l[w][31]);
        req = r;
        #1;
        check("grant", 64'(grant), 64'(4'b1 << w));
        @(negedge clk);
        req = '0;
        res_ready = (stall == 0);
        check("calc_busy", 64'(busy), 64'd1);
        check("calc_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("done_valid", 64'(res_valid), 64'd1);
        check("done_id", 64'(res_id), 64'(w));
        check("done_sum", 64'(res_sum), 64'(s[31:0]));
        check("done_cout", 64'(res_cout), 64'(s[32]));
`ifdef ADDER_SCHED_OVF_EN
        check("done_ovf", 64'(res_ovf), 64'(e_ovf));
        o_ovf = res_ovf;
`else
        o_ovf = e_ovf;
`endif
        o_id = res_id;
        o_sum = res_sum;
        o_cout = res_cout;
        for (int t = 0; t < stall; t++) begin
            req = 4'($urandom_range(1, 15));
            @(negedge clk);
            check("stall_valid", 64'(res_valid), 64'd1);
            check("stall_sum", 64'(res_sum), 64'(s[31:0]));
            check("stall_grant", 64'(grant), 64'd0);
        end
        req = '0;
        res_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 64'(res_valid), 64'd0);
        check("release_busy", 64'(busy), 64'd0);
        res_ready = 1'b0;
        mdl_ptr = (w + 1) % N;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] oid;
        logic [31:0] osum;
        logic ocout, oovf;
        int last;
        vt[0] = '{4'b0100, 32'h5, 32'h3, 1'b1, 5, 2'd2, 32'h9, 1'b0, 1'b0};
        vt[1] = '{4'b1000, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, 2'd3, 32'h0, 1'b1, 1'b0};
        vt[2] = '{4'b0001, 32'h7FFF_FFFF, 32'h1, 1'b0, 1, 2'd0, 32'h8000_0000, 1'b0, 1'b1};
        vt[3] = '{4'b0100, 32'h0, 32'h0, 1'b1, 0, 2'd2, 32'h1, 1'b0, 1'b0};
        vt[4] = '{4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2, 2'd1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vt[5] = '{4'b1010, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 2'd3, 32'h0, 1'b1, 1'b1};
        vt[6] = '{4'b1111, 32'h1, 32'h2, 1'b0, 0, 2'd0, 32'h3, 1'b0, 1'b0};
        vt[7] = '{4'b1001, 32'h1234_5678, 32'h1111_1111, 1'b1, 0, 2'd3, 32'h2345_678A, 1'b0, 1'b0};
        randomize_lanes();
        @(negedge clk);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_sum", 64'(res_sum), 64'd0);
        check("rst_id", 64'(res_id), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            randomize_lanes();
            a_l[vt[i].id] = vt[i].a;
            b_l[vt[i].id] = vt[i].b;
            cin[vt[i].id] = vt[i].c;
            run_op(vt[i].r, vt[i].stall, oid, osum, ocout, oovf);
            check("tbl_id", 64'(oid), 64'(vt[i].id));
            check("tbl_sum", 64'(osum), 64'(vt[i].sum));
            check("tbl_cout", 64'(ocout), 64'(vt[i].cout));
`ifdef ADDER_SCHED_OVF_EN
            check("tbl_ovf", 64'(oovf), 64'(vt[i].ovf));
`endif
        end
        // Abort an operation mid-CALC with an asynchronous reset.
        req = 4'b0010;
        #1;
        check("pre_rst_grant", 64'(grant), 64'b0010);
        @(negedge clk);
        req = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(res_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_grant", 64'(grant), 64'd0);
        check("abort_sum", 64'(res_sum), 64'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_ptr = 0;
        // Round-robin with all requests held and the consumer always ready.
        for (int i = 0; i < N; i++) begin
            a_l[i] = 32'(100 + i);
            b_l[i] = 32'(7 * i);
            cin[i] = 1'(i);
        end
        req = 4'b1111;
        res_ready = 1'b1;
        last = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            for (int t = 0; t < 8 && grant == '0; t++) @(negedge clk);
            check("rr_grant", 64'(grant), 64'(4'b1 << (i % N)));
            if (i > 0) check("rr_spacing", 64'(cyc - last), 64'd3);
            last = cyc;
            @(negedge clk);
            @(negedge clk);
            check("rr_id", 64'(res_id), 64'(i % N));
            check("rr_sum", 64'(res_sum), 64'(100 + 8 * (i % N) + (i % 2)));
            if (i == 4) req = '0;
            @(negedge clk);
        end
        res_ready = 1'b0;
        mdl_ptr = 1;
        for (int n = 0; n < 40; n++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            randomize_lanes();
            if (r == 4'b0) begin
                req = '0;
                res_ready = 1'($urandom);
                #1;
                check("idle_grant", 64'(grant), 64'd0);
                @(negedge clk);
                check("idle_busy", 64'(busy), 64'd0);
                res_ready = 1'b0;
            end else begin
                run_op(r, $urandom_range(0, 3), oid, osum, ocout, oovf);
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
